// File: rtl/i2c_target_regfile.sv
// I2C target with a 256x8 register file: oversamples SCL/SDA on clock_50, ACKs its
// address, loads a register pointer, stores written bytes and serves reads.
module i2c_target_regfile #(
    parameter logic [6:0] DEVICE_ADDR = 7'h39,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       i2c_serial_clock,
    inout  wire        i2c_serial_data,
    input  logic [7:0] reg_addr,
    output logic [7:0] reg_rdata,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    state_t      state_q;
    logic [3:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  ptr_q;
    logic        phase_q;
    logic        rw_q;
    logic        sda_oe_q;
    logic        busy_q;
    logic        wr_valid_q;
    logic [7:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [7:0]  reg_rdata_q;
    logic [7:0]  mem_q [256];

    logic       scl_s;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] rx_byte_d;
    logic [7:0] ptr_inc_d;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte_d = {shift_q, sda_s};
    assign ptr_inc_d = ptr_q + 8'd1;

    // Idle bus is high; resetting the synchronizers high avoids a phantom START/STOP.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_serial_clock};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_serial_data};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // NOTE: the register file is cleared by reset because its contents are architecturally
    // visible as 0x00 after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            phase_q    <= 1'b0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_valid_q <= 1'b0;
            if (start_det) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= '0;
                phase_q   <= 1'b0;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q  <= S_IDLE;
                phase_q  <= 1'b0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= '0;
                                if (state_q == S_ADDR) begin
                                    if (rx_byte_d[7:1] == DEVICE_ADDR) begin
                                        state_q <= S_ADDR_ACK;
                                        rw_q    <= rx_byte_d[0];
                                        busy_q  <= 1'b1;
                                    end else begin
                                        state_q <= S_IGNORE;
                                        busy_q  <= 1'b0;
                                    end
                                end else if (state_q == S_PTR) begin
                                    ptr_q   <= rx_byte_d;
                                    state_q <= S_PTR_ACK;
                                end else begin
                                    mem_q[ptr_q] <= rx_byte_d;
                                    wr_valid_q   <= 1'b1;
                                    wr_addr_q    <= ptr_q;
                                    wr_data_q    <= rx_byte_d;
                                    ptr_q        <= ptr_inc_d;
                                    state_q      <= S_WDATA_ACK;
                                end
                            end
                        end
                    end
                    // ACK is held low from the SCL fall after bit 8 to the fall after bit 9.
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            phase_q  <= ~phase_q;
                            sda_oe_q <= ~phase_q;
                            if (phase_q) begin
                                bit_cnt_q <= '0;
                                if (state_q == S_ADDR_ACK && rw_q) begin
                                    state_q  <= S_RDATA;
                                    shift_q  <= mem_q[ptr_q][6:0];
                                    sda_oe_q <= ~mem_q[ptr_q][7];
                                end else if (state_q == S_ADDR_ACK) begin
                                    state_q <= S_PTR;
                                end else begin
                                    state_q <= S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                ptr_q <= ptr_inc_d;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= S_RDATA_ACK;
                            end else begin
                                sda_oe_q <= ~shift_q[6];
                                shift_q  <= {shift_q[5:0], 1'b0};
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state_q <= S_IGNORE;
                                busy_q  <= 1'b0;
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            phase_q   <= 1'b0;
                            bit_cnt_q <= '0;
                            shift_q   <= mem_q[ptr_q][6:0];
                            sda_oe_q  <= ~mem_q[ptr_q][7];
                            state_q   <= S_RDATA;
                        end
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Non-blocking read sees the pre-write contents when an I2C write lands the same cycle.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            reg_rdata_q <= '0;
        end else begin
            reg_rdata_q <= mem_q[reg_addr];
        end
    end

    assign i2c_serial_data = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_rdata       = reg_rdata_q;
    assign wr_valid        = wr_valid_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged I2C master on an open-drain bus,
// table-driven write transactions plus hand sequences for reads and mid-transfer reset.
module tb_i2c_target_regfile;

    localparam int TQ = 4;

    typedef struct packed {
        logic [7:0] dev;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] n;
        logic       exp_ack;
    } vec_t;

    logic       clock_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       scl      = 1'b1;
    logic       m_sda    = 1'b1;
    logic [7:0] reg_addr = 8'h00;
    wire  [7:0] reg_rdata;
    wire        wr_valid;
    wire  [7:0] wr_addr;
    wire  [7:0] wr_data;
    wire        busy;
    wire        sda;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    i2c_target_regfile dut (
        .clock_50         (clock_50),
        .reset            (reset),
        .i2c_serial_clock (scl),
        .i2c_serial_data  (sda),
        .reg_addr         (reg_addr),
        .reg_rdata        (reg_rdata),
        .wr_valid         (wr_valid),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .busy             (busy)
    );

    always #10 clock_50 = ~clock_50;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [23:0] wr_q [$];
    logic [7:0]  model [256];
    vec_t        vecs [5];

    // Each write pulse is logged with the local read data registered on the same edge.
    always @(negedge clock_50) begin
        if (wr_valid === 1'b1) wr_q.push_back({wr_addr, wr_data, reg_rdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock_50);
        #1;
    endtask

    function automatic logic bus_bit();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic i2c_start();
        m_sda = 1'b1; tick(TQ);
        scl   = 1'b1; tick(TQ);
        m_sda = 1'b0; tick(TQ);
        scl   = 1'b0; tick(TQ);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(TQ);
        scl   = 1'b1; tick(TQ);
        m_sda = 1'b1; tick(TQ);
    endtask

    task automatic i2c_bit(input logic b, output logic got);
        m_sda = b;    tick(TQ);
        scl   = 1'b1; tick(TQ);
        got   = bus_bit();
        tick(TQ);
        scl   = 1'b0; tick(TQ);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic g;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], g);
        i2c_bit(1'b1, g);
        acked = ~g;
    endtask

    task automatic recv_byte(input logic master_nack, output logic [7:0] b);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, g);
            b[i] = g;
        end
        i2c_bit(master_nack, g);
    endtask

    task automatic read_local(input logic [7:0] a, output logic [7:0] d);
        reg_addr = a;
        tick(1);
        d = reg_rdata;
    endtask

    task automatic read_pair(input logic [7:0] p, input string tag);
        logic       ack;
        logic [7:0] b;
        logic [7:0] a1;
        a1 = p + 8'd1;
        i2c_start();
        send_byte(8'h72, ack); check({tag, " wr_addr_ack"}, ack, 1'b1);
        send_byte(p, ack);     check({tag, " ptr_ack"}, ack, 1'b1);
        i2c_start();
        send_byte(8'h73, ack); check({tag, " rd_addr_ack"}, ack, 1'b1);
        check({tag, " busy_rd"}, busy, 1'b1);
        recv_byte(1'b0, b);    check({tag, " byte0"}, b, model[p]);
        recv_byte(1'b1, b);    check({tag, " byte1"}, b, model[a1]);
        check({tag, " busy_after_nack"}, busy, 1'b0);
        check({tag, " sda_released"}, bus_bit(), 1'b1);
        i2c_stop();
    endtask

    initial begin
        vec_t       t;
        logic       ack;
        logic       g;
        logic [7:0] b;
        logic [7:0] a;
        logic [7:0] d;
        int         exp_n;

        vecs[0] = '{dev: 8'h72, ptr: 8'h41, d0: 8'h00, d1: 8'h00, n: 2'd1, exp_ack: 1'b1};
        vecs[1] = '{dev: 8'h72, ptr: 8'h98, d0: 8'h03, d1: 8'h70, n: 2'd2, exp_ack: 1'b1};
        vecs[2] = '{dev: 8'h70, ptr: 8'h41, d0: 8'h55, d1: 8'h00, n: 2'd1, exp_ack: 1'b0};
        vecs[3] = '{dev: 8'h72, ptr: 8'hFF, d0: 8'hAA, d1: 8'hBB, n: 2'd2, exp_ack: 1'b1};
        vecs[4] = '{dev: 8'h72, ptr: 8'h10, d0: 8'h00, d1: 8'h00, n: 2'd0, exp_ack: 1'b1};
        for (int i = 0; i < 256; i++) model[i] = 8'h00;

        tick(4);
        check("rst sda", bus_bit(), 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst wr_valid", wr_valid, 1'b0);
        check("rst rdata", reg_rdata, 8'h00);
        reset = 1'b0;
        tick(4);

        for (int v = 0; v < 5; v++) begin
            t = vecs[v];
            wr_q.delete();
            reg_addr = t.ptr;
            tick(2);
            i2c_start();
            send_byte(t.dev, ack);
            check($sformatf("v%0d addr_ack", v), ack, t.exp_ack);
            check($sformatf("v%0d busy", v), busy, t.exp_ack);
            send_byte(t.ptr, ack);
            check($sformatf("v%0d ptr_ack", v), ack, t.exp_ack);
            for (int k = 0; k < int'(t.n); k++) begin
                send_byte((k == 0) ? t.d0 : t.d1, ack);
                check($sformatf("v%0d data%0d_ack", v, k), ack, t.exp_ack);
            end
            i2c_stop();
            check($sformatf("v%0d busy_after_stop", v), busy, 1'b0);
            exp_n = t.exp_ack ? int'(t.n) : 0;
            check($sformatf("v%0d wr_count", v), wr_q.size(), exp_n);
            for (int k = 0; k < exp_n; k++) begin
                a = t.ptr + 8'(k);
                d = (k == 0) ? t.d0 : t.d1;
                if (wr_q.size() > k) begin
                    check($sformatf("v%0d wr_addr%0d", v, k), wr_q[k][23:16], a);
                    check($sformatf("v%0d wr_data%0d", v, k), wr_q[k][15:8], d);
                    if (k == 0) check($sformatf("v%0d rd_before_wr", v), wr_q[k][7:0], model[a]);
                end
                model[a] = d;
            end
            for (int k = 0; k < 2; k++) begin
                a = t.ptr + 8'(k);
                read_local(a, d);
                check($sformatf("v%0d reg[%0h]", v, a), d, model[a]);
            end
        end

        wr_q.delete();
        read_pair(8'h98, "rd98");
        read_pair(8'hFF, "rdwrap");
        check("rd no_writes", wr_q.size(), 0);

        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'h98, ack);
        i2c_start();
        send_byte(8'h73, ack);
        check("rst_mid sda_driven", bus_bit(), 1'b0);
        reset = 1'b1;
        tick(1);
        check("rst_mid sda_released", bus_bit(), 1'b1);
        check("rst_mid busy", busy, 1'b0);
        tick(1);
        reset = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, g);
            b[i] = g;
        end
        check("rst_mid bits_ignored", b, 8'hFF);
        i2c_stop();
        check("rst_mid no_writes", wr_q.size(), 0);
        for (int i = 0; i < 256; i++) model[i] = 8'h00;

        i2c_start();
        send_byte(8'h72, ack); check("post_rst addr_ack", ack, 1'b1);
        send_byte(8'h20, ack); check("post_rst ptr_ack", ack, 1'b1);
        send_byte(8'h77, ack); check("post_rst data_ack", ack, 1'b1);
        i2c_stop();
        check("post_rst wr_count", wr_q.size(), 1);
        read_local(8'h20, d); check("post_rst reg[20]", d, 8'h77);
        read_local(8'h98, d); check("post_rst reg[98]", d, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
